// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one combinational ALU between two requesters
// Accept in IDLE, drive the ALU for one EXEC cycle, hold the result in RESP until consumed.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_r1,
  input  logic [WIDTH-1:0] req0_r2,
  input  logic [OPW-1:0]   req0_sub,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_sum,
  output logic             resp0_overflow,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_r1,
  input  logic [WIDTH-1:0] req1_r2,
  input  logic [OPW-1:0]   req1_sub,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_sum,
  output logic             resp1_overflow,
  output logic [WIDTH-1:0] alu_r1,
  output logic [WIDTH-1:0] alu_r2,
  output logic [OPW-1:0]   alu_sub,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [OPW-1:0]   sub_q, sub_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic win_valid;
  logic win_id;
  logic accept;
  logic resp_fire;

  always_comb begin
    win_valid = req0_valid | req1_valid;
    // ptr_q names the requester that wins a tie; a lone requester always wins.
    win_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept    = (state_q == IDLE) && win_valid;
    resp_fire = (state_q == RESP) && (grant_q ? resp1_ready : resp0_ready);

    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = win_id;
          ptr_d   = ~win_id;
          r1_d    = win_id ? req1_r1  : req0_r1;
          r2_d    = win_id ? req1_r2  : req0_r2;
          sub_d   = win_id ? req1_sub : req0_sub;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = alu_sum;
        ovf_d   = alu_overflow;
        state_d = RESP;
      end
      RESP: begin
        if (resp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      sub_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ready is combinational from valid, so it is gated by reset to keep outputs low in reset.
  assign req0_ready = rst_n && accept && !win_id;
  assign req1_ready = rst_n && accept &&  win_id;

  assign resp0_valid    = (state_q == RESP) && !grant_q;
  assign resp1_valid    = (state_q == RESP) &&  grant_q;
  assign resp0_sum      = resp0_valid ? sum_q : '0;
  assign resp1_sum      = resp1_valid ? sum_q : '0;
  assign resp0_overflow = resp0_valid & ovf_q;
  assign resp1_overflow = resp1_valid & ovf_q;

  assign alu_r1     = r1_q;
  assign alu_r2     = r2_q;
  assign alu_sub    = sub_q;
  assign alu_enable = (state_q == EXEC);
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
// The ALU is a small bench model: op 4'b1001 is shift-right-logical, anything else is signed add.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_r1, req0_r2, req1_r1, req1_r2;
  logic [3:0]  req0_sub, req1_sub;
  logic        resp0_valid, resp0_ready, resp0_overflow;
  logic        resp1_valid, resp1_ready, resp1_overflow;
  logic [31:0] resp0_sum, resp1_sum;
  logic [31:0] alu_r1, alu_r2, alu_sum;
  logic [3:0]  alu_sub;
  logic        alu_enable, alu_overflow, busy, grant_id;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_sum      = alu_r1 + alu_r2;
    alu_overflow = (alu_r1[31] == alu_r2[31]) && (alu_sum[31] != alu_r1[31]);
    if (alu_sub == 4'b1001) begin
      alu_sum      = alu_r1 >> alu_r2[4:0];
      alu_overflow = 1'b0;
    end
  end

  alu_share_arb #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r1(req0_r1),
    .req0_r2(req0_r2), .req0_sub(req0_sub),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_sum(resp0_sum), .resp0_overflow(resp0_overflow),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r1(req1_r1),
    .req1_r2(req1_r2), .req1_sub(req1_sub),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_sum(resp1_sum), .resp1_overflow(resp1_overflow),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_sub(alu_sub), .alu_enable(alu_enable),
    .alu_sum(alu_sum), .alu_overflow(alu_overflow),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic clear_inputs();
    req0_valid = 0; req0_r1 = 0; req0_r2 = 0; req0_sub = 0; resp0_ready = 1;
    req1_valid = 0; req1_r1 = 0; req1_r2 = 0; req1_sub = 0; resp1_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [164:0] outs;
    int en_seen;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'($urandom); req0_r1 = $urandom; req0_r2 = $urandom; req0_sub = 4'($urandom);
      req1_valid = 1'($urandom); req1_r1 = $urandom; req1_r2 = $urandom; req1_sub = 4'($urandom);
      resp0_ready = 1'($urandom); resp1_ready = 1'($urandom);
      #1;
      outs = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_sum, resp1_sum,
              resp0_overflow, resp1_overflow, alu_r1, alu_r2, alu_sub, alu_enable, busy, grant_id};
      n_asserts++;
      if (outs !== '0) begin
        n_fail++; $display("FAIL reset_outputs: got %h, want 0", outs);
      end
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (alu_enable || busy) en_seen++;
    end
    n_asserts++;
    if (en_seen !== 0) begin
      n_fail++; $display("FAIL reset_idle: got %0d busy/enable cycles, want 0", en_seen);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_r1 = 32'h8; req0_r2 = 32'h1; req0_sub = 4'b1001;
    #1;
    n_asserts++;
    if ({req0_ready, req1_ready, alu_enable} !== 3'b100) begin
      n_fail++; $display("FAIL single_accept: got rdy0/rdy1/en=%b, want 100", {req0_ready, req1_ready, alu_enable});
    end
    @(negedge clk);
    req0_valid = 0;
    #1;
    n_asserts++;
    if ({alu_enable, busy, grant_id, req0_ready} !== 4'b1100 || alu_r1 !== 32'h8 || alu_r2 !== 32'h1 || alu_sub !== 4'b1001) begin
      n_fail++; $display("FAIL single_exec: got en/busy/gid/rdy=%b r1=%h r2=%h sub=%h, want 1100 8 1 9",
                         {alu_enable, busy, grant_id, req0_ready}, alu_r1, alu_r2, alu_sub);
    end
    @(negedge clk);
    n_asserts++;
    if ({alu_enable, resp0_valid, resp0_overflow, resp1_valid} !== 4'b0100 || resp0_sum !== 32'h4 || alu_r1 !== 32'h8) begin
      n_fail++; $display("FAIL single_resp: got en/v0/ov/v1=%b sum=%h alu_r1=%h, want 0100 4 8",
                         {alu_enable, resp0_valid, resp0_overflow, resp1_valid}, resp0_sum, alu_r1);
    end
    @(negedge clk);
    n_asserts++;
    if ({busy, resp0_valid, resp0_sum} !== 34'h0) begin
      n_fail++; $display("FAIL single_done: got busy=%b v0=%b sum=%h, want 0 0 0", busy, resp0_valid, resp0_sum);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    req1_valid = 1; req1_r1 = 32'h7fff_ffff; req1_r2 = 32'h1; req1_sub = 4'b0000;
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    n_asserts++;
    if ({resp1_valid, resp1_overflow, resp0_valid, resp0_overflow} !== 4'b1100 || resp1_sum !== 32'h8000_0000) begin
      n_fail++; $display("FAIL overflow_resp: got v1/ov1/v0/ov0=%b sum=%h, want 1100 80000000",
                         {resp1_valid, resp1_overflow, resp0_valid, resp0_overflow}, resp1_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0_valid = 1; req0_r1 = 32'h4; req0_r2 = 32'h1; req0_sub = 4'b1001;
    req1_valid = 1; req1_r1 = 32'h2; req1_r2 = 32'h1; req1_sub = 4'b1001;
    #1;
    n_asserts++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL sim_first_win: got rdy0/rdy1=%b, want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 0;
    #1;
    n_asserts++;
    if ({grant_id, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL sim_grant0: got gid/rdy1=%b, want 00", {grant_id, req1_ready});
    end
    @(negedge clk);
    n_asserts++;
    if (resp0_valid !== 1'b1 || resp0_sum !== 32'h2 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL sim_resp0: got v0=%b sum=%h rdy1=%b, want 1 2 0", resp0_valid, resp0_sum, req1_ready);
    end
    @(negedge clk);
    n_asserts++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL sim_second_accept: got rdy1=%b, want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 0;
    #1;
    n_asserts++;
    if (grant_id !== 1'b1 || alu_r1 !== 32'h2) begin
      n_fail++; $display("FAIL sim_grant1: got gid=%b alu_r1=%h, want 1 2", grant_id, alu_r1);
    end
    @(negedge clk);
    n_asserts++;
    if ({resp1_valid, resp0_valid} !== 2'b10 || resp1_sum !== 32'h1) begin
      n_fail++; $display("FAIL sim_resp1: got v1/v0=%b sum=%h, want 10 1", {resp1_valid, resp0_valid}, resp1_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    resp1_ready = 0;
    req1_valid = 1; req1_r1 = 32'h100; req1_r2 = 32'h4; req1_sub = 4'b1001;
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_r1 = 32'h30; req0_r2 = 32'h4; req0_sub = 4'b1001;
    #1;
    n_asserts++;
    if (req0_ready !== 1'b0 || alu_enable !== 1'b1) begin
      n_fail++; $display("FAIL bp_exec: got rdy0=%b en=%b, want 0 1", req0_ready, alu_enable);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp1_valid !== 1'b1 || resp1_sum !== 32'h10 || req0_ready !== 1'b0) bad++;
    end
    n_asserts++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
    end
    resp1_ready = 1;
    @(negedge clk);
    n_asserts++;
    if ({req0_ready, resp1_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got rdy0/v1=%b, want 10", {req0_ready, resp1_valid});
    end
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    n_asserts++;
    if (resp0_valid !== 1'b1 || resp0_sum !== 32'h3) begin
      n_fail++; $display("FAIL bp_req0_resp: got v0=%b sum=%h, want 1 3", resp0_valid, resp0_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int grants, errs, exp_id;
    do_reset();
    req0_valid = 1; req0_r1 = 32'h1; req0_r2 = 32'h1; req0_sub = 4'b1001;
    req1_valid = 1; req1_r1 = 32'h1; req1_r2 = 32'h1; req1_sub = 4'b1001;
    grants = 0; errs = 0;
    for (int cyc = 0; cyc < 60 && grants < 12; cyc++) begin
      #1;
      if (req0_ready && req1_ready) errs++;
      if (req0_ready || req1_ready) begin
        exp_id = grants % 2;
        if (req1_ready !== exp_id[0]) begin
          errs++; $display("FAIL fair_order: grant %0d got id=%b, want %0d", grants, req1_ready, exp_id);
        end
        grants++;
      end
      if ((resp0_valid && resp0_sum !== 32'h0) || (resp1_valid && resp1_sum !== 32'h0)) errs++;
      @(negedge clk);
    end
    n_asserts++;
    if (errs !== 0 || grants !== 12) begin
      n_fail++; $display("FAIL fairness: got %0d errors, %0d grants, want 0 and 12", errs, grants);
    end
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen1;
    req1_valid = 1; req1_r1 = 32'h40; req1_r2 = 32'h2; req1_sub = 4'b1001;
    @(negedge clk);
    req1_valid = 0;
    #1;
    n_asserts++;
    if ({alu_enable, grant_id} !== 2'b11) begin
      n_fail++; $display("FAIL mid_exec: got en/gid=%b, want 11", {alu_enable, grant_id});
    end
    rst_n = 0;
    #1;
    n_asserts++;
    if ({alu_enable, busy, grant_id, resp1_valid} !== 4'b0000 || alu_r1 !== 32'h0) begin
      n_fail++; $display("FAIL mid_async: got en/busy/gid/v1=%b alu_r1=%h, want 0000 0",
                         {alu_enable, busy, grant_id, resp1_valid}, alu_r1);
    end
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_r1 = 32'h9; req0_r2 = 32'h0; req0_sub = 4'b1001;
    req1_valid = 1;
    #1;
    n_asserts++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_ptr: got rdy0/rdy1=%b, want 10", {req0_ready, req1_ready});
    end
    seen1 = 0;
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    if (resp1_valid) seen1++;
    @(negedge clk);
    if (resp1_valid) seen1++;
    n_asserts++;
    if (seen1 !== 0 || resp0_valid !== 1'b1 || resp0_sum !== 32'h9) begin
      n_fail++; $display("FAIL mid_after: got stale v1 %0d, v0=%b sum=%h, want 0 1 9", seen1, resp0_valid, resp0_sum);
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_simultaneous();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-port arbiter and sequencer that time-shares the single 32-bit combinational `alu` between two requesters, e.g. the EXU main path and an address/branch helper.
- Each requester issues an operation (r1, r2, sub) over a valid/ready handshake.
- The block grants one request at a time in round-robin order and drives the shared ALU for exactly one cycle.
- It registers sum/overflow and returns them on a per-requester response handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the `alu` datapath.
- OPW, 4, width of the `sub` operation code.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_r1  input  WIDTH  requester 0 operand 1
- req0_r2  input  WIDTH  requester 0 operand 2 / shift amount
- req0_sub  input  OPW  requester 0 ALU op code
- resp0_valid  output  1  result for requester 0 available
- resp0_ready  input  1  requester 0 consumes result
- resp0_sum  output  WIDTH  result for requester 0
- resp0_overflow  output  1  overflow flag for requester 0
- req1_* / resp1_*  same set and widths as port 0, for requester 1
- alu_r1  output  WIDTH  to alu.r1
- alu_r2  output  WIDTH  to alu.r2
- alu_sub  output  OPW  to alu.sub
- alu_enable  output  1  to alu.alu_enable
- alu_sum  input  WIDTH  from alu.sum
- alu_overflow  input  1  from alu.overflow
- busy  output  1  high in any state other than IDLE
- grant_id  output  1  requester currently owning the ALU; valid while busy

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all outputs 0.
  - Operand, op and result registers cleared.
  - Round-robin pointer set so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational, asserted only in IDLE and only for the arbitration winner.
  - Winner rule: a sole valid requester wins. If both are valid, the requester not granted last wins.
  - Handshake (valid&ready) at cycle N:
    - latch r1/r2/sub and grant_id;
    - point the pointer at the other requester;
    - go to EXEC.
  - No valid request: stay in IDLE.
  - A requester may drop valid before acceptance with no effect.
- EXEC (cycle N+1):
  - alu_enable=1; alu_r1/alu_r2/alu_sub driven from the latched registers.
  - alu_sum/alu_overflow captured into the result register at the clock edge.
  - Then go to RESP.
- Outside EXEC:
  - alu_enable=0.
  - alu_r1/alu_r2/alu_sub hold the last latched values, so the ALU inputs do not toggle.
- RESP (from cycle N+2):
  - respX_valid=1 for X=grant_id only; the other resp_valid stays 0.
  - respX_sum/respX_overflow show the result register, and are 0 when not valid.
  - Data stable while valid&&!ready.
  - On respX_ready, return to IDLE the next cycle.
  - A new request can be accepted in that IDLE cycle.
- Timing:
  - Latency from accept to resp_valid is 2 cycles.
  - Minimum issue interval is 3 cycles per op.
- No reqX_ready in EXEC or RESP.
  - Requests arriving then wait, with valid held high by the requester.
- Arithmetic is fully delegated to the ALU; the block never modifies operands or result.
- resp_ready asserted outside RESP is ignored.
- Reset asserted in EXEC or RESP:
  - the transaction is dropped and no response is produced;
  - all outputs go to 0 immediately;
  - after release, the pointer favours requester 0 again.
- Starvation-free: with both valid continuously, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset check: hold rst_n=0 with random inputs → all outputs 0, busy=0; release with no valid → stays idle, alu_enable never 1.
- Single op, no contention: req0 r1=32'h8, r2=32'h1, sub=4'b1001 (SRLI) accepted at cycle N → alu_enable=1 only at N+1; resp0_valid=1 at N+2 with resp0_sum=32'h4, overflow=0; resp1_valid stays 0.
- Simultaneous requests after reset: req0 (r1=4, SRLI, r2=1) and req1 (r1=2, SRLI, r2=1) in the same cycle, resp ready always 1:
  - req0 granted first, resp0_sum=2;
  - req1 accepted 3 cycles after req0, resp1_sum=1;
  - grant_id sequence 0 then 1.
- Backpressure: resp1_ready held 0 for 5 cycles during RESP → resp1_valid and resp1_sum stay constant; req0_ready stays 0 throughout; after resp1_ready=1, req0 is accepted the following cycle.
- Fairness: both requesters valid continuously for 12 ops (r1=32'h1, SRLI 1 → sum 0) → grants alternate exactly 0,1,0,1… with no requester granted twice in a row.
- Reset mid-operation: assert rst_n=0 during EXEC of a req1 op → no resp1_valid ever for it; after release with both valid, req0 is granted first.
